// File: rtl/icache_control_if.sv
// Fetch-side, datapath-control and physical-memory signals of the icache controller.
// The controller takes the slave view; the environment (fetch stage, datapath, pmem) takes the master view.
interface icache_control_if #(
  parameter int CNT_WIDTH = 32
);
  // fetch stage
  logic                 mem_read;
  logic [31:0]          mem_address;
  logic                 mem_resp;
  // datapath control
  logic [31:0]          dp_address;
  logic                 hit;
  logic                 way_sel_method;
  logic                 load_line_data;
  logic                 load_valid;
  logic                 valid_in;
  logic                 load_LRU;
  logic                 rdata_sel;
  logic                 load_dirty;
  logic                 dirty_in;
  logic                 load_wdata_reg;
  logic                 line_datain_sel;
  logic                 address_sel;
  // physical memory
  logic                 pmem_read;
  logic                 pmem_resp;
  // status and counters
  logic                 busy;
  logic                 clr_counters;
  logic [CNT_WIDTH-1:0] hit_count;
  logic [CNT_WIDTH-1:0] miss_count;

  modport slave (
    input  mem_read, mem_address, hit, pmem_resp, clr_counters,
    output mem_resp, dp_address, way_sel_method, load_line_data, load_valid, valid_in,
           load_LRU, rdata_sel, load_dirty, dirty_in, load_wdata_reg, line_datain_sel,
           address_sel, pmem_read, busy, hit_count, miss_count
  );

  modport master (
    output mem_read, mem_address, hit, pmem_resp, clr_counters,
    input  mem_resp, dp_address, way_sel_method, load_line_data, load_valid, valid_in,
           load_LRU, rdata_sel, load_dirty, dirty_in, load_wdata_reg, line_datain_sel,
           address_sel, pmem_read, busy, hit_count, miss_count
  );
endinterface

// File: rtl/icache_control.sv
// Sequencer for the 2-way read-only instruction cache: same-cycle hits, latched-address
// line fill with critical-word forwarding, and saturating hit/miss counters.
module icache_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  icache_control_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [31:0]          miss_addr_q, miss_addr_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  logic req_hit, req_miss, fill_done, line_match;

  assign req_hit    = (state_q == IDLE) && bus.mem_read &&  bus.hit;
  assign req_miss   = (state_q == IDLE) && bus.mem_read && !bus.hit;
  assign fill_done  = (state_q == FETCH) && bus.pmem_resp;
  assign line_match = (bus.mem_address[31:5] == miss_addr_q[31:5]);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // next state; the miss line is frozen so a fetch redirect cannot retarget the fill
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    unique case (state_q)
      IDLE: begin
        if (req_miss) begin
          state_d     = FETCH;
          miss_addr_d = {bus.mem_address[31:5], 5'b0};
        end
      end
      FETCH: begin
        if (bus.pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // saturating counters, clear wins over a same-cycle increment
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.clr_counters) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (req_hit  && !(&hit_cnt_q))  hit_cnt_d  = hit_cnt_q  + CNT_WIDTH'(1);
      if (req_miss && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  // outputs; held quiet while reset is asserted
  always_comb begin
    bus.dp_address     = bus.mem_address;
    bus.way_sel_method = 1'b0;
    bus.mem_resp       = 1'b0;
    bus.load_line_data = 1'b0;
    bus.load_valid     = 1'b0;
    bus.valid_in       = 1'b0;
    bus.load_LRU       = 1'b0;
    bus.rdata_sel      = 1'b0;
    bus.pmem_read      = 1'b0;
    bus.busy           = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (req_hit) begin
            bus.mem_resp = 1'b1;
            bus.load_LRU = 1'b1;
          end
        end
        FETCH: begin
          bus.dp_address     = {miss_addr_q[31:5], bus.mem_address[4:0]};
          bus.way_sel_method = 1'b1;
          bus.pmem_read      = 1'b1;
          bus.busy           = 1'b1;
          if (fill_done) begin
            bus.load_line_data = 1'b1;
            bus.load_valid     = 1'b1;
            bus.valid_in       = 1'b1;
            bus.load_LRU       = 1'b1;
            bus.rdata_sel      = 1'b1;
            // forward the critical word only if the fetch still wants this line
            bus.mem_resp       = bus.mem_read && line_match;
          end
        end
        default: ;
      endcase
    end
  end

  // read-only cache: write-path controls never move
  assign bus.load_dirty      = 1'b0;
  assign bus.dirty_in        = 1'b0;
  assign bus.load_wdata_reg  = 1'b0;
  assign bus.line_datain_sel = 1'b0;
  assign bus.address_sel     = 1'b0;

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_control.sv
// Randomized scoreboard bench for icache_control with an emulated 2-way datapath and pmem.
module tb_icache_control;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_control_if #(.CNT_WIDTH(CW)) bus();
  icache_control #(.CNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- emulated datapath (driven only by DUT strobes) ----------------
  logic        dv [8][2];
  logic [23:0] dt [8][2];
  logic        dl [8];
  logic        dp_clear;
  logic [2:0]  dset;
  logic [23:0] dtag;
  logic        h0, h1, dsel;
  assign dset    = bus.dp_address[7:5];
  assign dtag    = bus.dp_address[31:8];
  assign h0      = dv[dset][0] && (dt[dset][0] == dtag);
  assign h1      = dv[dset][1] && (dt[dset][1] == dtag);
  assign bus.hit = h0 | h1;
  assign dsel    = bus.way_sel_method ? dl[dset] : ~h0;

  always @(posedge clk) begin
    if (dp_clear) begin
      for (int s = 0; s < 8; s++) begin
        dv[s][0] <= 1'b0;
        dv[s][1] <= 1'b0;
        dl[s]    <= 1'b0;
      end
    end else begin
      if (bus.load_line_data) dt[dset][dsel] <= dtag;
      if (bus.load_valid)     dv[dset][dsel] <= bus.valid_in;
      if (bus.load_LRU)       dl[dset]       <= ~dsel;
    end
  end

  // ---------------- emulated physical memory ----------------
  int   pmem_lat = 1;
  bit   pmem_en = 1'b1;
  logic pmem_auto = 1'b0;
  logic pmem_force = 1'b0;
  assign bus.pmem_resp = pmem_auto | pmem_force;

  initial begin
    int pcnt;
    pcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (pmem_auto) begin
        pmem_auto = 1'b0;
        pcnt = 0;
      end else if (bus.pmem_read) begin
        pcnt++;
        if (pmem_en && pcnt >= pmem_lat) pmem_auto = 1'b1;
      end else pcnt = 0;
    end
  end

  // ---------------- reference model: per-set recency list of line addresses ----------------
  logic [26:0] r_mru [8];
  logic [26:0] r_lru [8];
  int          r_n   [8];
  int          r_hits = 0;
  int          r_miss = 0;

  task automatic ref_access(input logic [31:0] a, output logic miss);
    logic [26:0] line;
    int s;
    line = a[31:5];
    s = int'(a[7:5]);
    if (r_n[s] >= 1 && r_mru[s] == line) miss = 1'b0;
    else if (r_n[s] == 2 && r_lru[s] == line) begin
      r_lru[s] = r_mru[s];
      r_mru[s] = line;
      miss = 1'b0;
    end else begin
      r_lru[s] = r_mru[s];
      r_mru[s] = line;
      if (r_n[s] < 2) r_n[s]++;
      miss = 1'b1;
    end
    if (miss) begin if (r_miss < SAT) r_miss++; end
    else      begin if (r_hits < SAT) r_hits++; end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic        miss;
  } exp_t;
  exp_t sbq[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("busy_vs_pmem_read", {31'b0, bus.pmem_read}, {31'b0, bus.busy});
      chk("tied_zero", {27'b0, bus.load_dirty, bus.dirty_in, bus.load_wdata_reg,
                        bus.line_datain_sel, bus.address_sel}, 32'h0);
      if (bus.mem_resp) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got mem_resp at dp_address %h expected none", bus.dp_address);
        end else begin
          e = sbq.pop_front();
          chk("resp_addr", bus.dp_address, e.addr);
          chk("resp_rdata_sel", {31'b0, bus.rdata_sel}, {31'b0, e.miss});
          chk("resp_fill", {31'b0, bus.load_line_data}, {31'b0, e.miss});
          chk("resp_valid", {30'b0, bus.load_valid, bus.valid_in}, {30'b0, e.miss, e.miss});
          chk("resp_way_sel", {31'b0, bus.way_sel_method}, {31'b0, e.miss});
          chk("resp_load_lru", {31'b0, bus.load_LRU}, 32'h1);
        end
      end
    end
  end

  // ---------------- stimulus helpers (entered and left at posedge+1) ----------------
  task automatic start_req(input logic [31:0] a, input int lat, output logic miss);
    ref_access(a, miss);
    sbq.push_back('{a, miss});
    pmem_lat = lat;
    bus.mem_read = 1'b1;
    bus.mem_address = a;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_resp) break;
      cyc++;
      if (cyc > 20) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout: got no mem_resp for %h expected one within 20 cycles", bus.mem_address);
        break;
      end
    end
    @(posedge clk); #1;
    bus.mem_read = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input int lat, output int cyc);
    logic miss;
    start_req(a, lat, miss);
    wait_resp(cyc);
    chk("latency", cyc, miss ? lat : 0);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_hit_count"}, 32'(bus.hit_count), r_hits);
    chk({tag, "_miss_count"}, 32'(bus.miss_count), r_miss);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic m;
    logic [31:0] a;
    bus.mem_read = 1'b0;
    bus.mem_address = 32'h1234_5678;
    bus.clr_counters = 1'b0;
    dp_clear = 1'b1;
    for (int s = 0; s < 8; s++) r_n[s] = 0;
    repeat (2) @(posedge clk);
    #1 dp_clear = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_strobes", {23'b0, bus.mem_resp, bus.pmem_read, bus.busy, bus.load_line_data, bus.load_valid,
                        bus.valid_in, bus.load_LRU, bus.rdata_sel, bus.way_sel_method}, 32'h0);
    chk("rst_dp_address", bus.dp_address, 32'h1234_5678);
    chk_counters("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // cold fetch then same-line refetch
    fetch(32'h0000_0040, 3, cyc);
    chk_counters("cold");
    fetch(32'h0000_0044, 2, cyc);
    chk("refetch_hit_latency", cyc, 0);
    chk_counters("refetch");

    // LRU eviction in set 0
    fetch(32'h0000_0000, 1, cyc);
    fetch(32'h0000_0100, 2, cyc);
    fetch(32'h0000_0200, 4, cyc);
    fetch(32'h0000_0100, 1, cyc);
    chk("lru_keep_0x100", cyc, 0);
    fetch(32'h0000_0000, 2, cyc);
    chk("lru_evicted_0x000", cyc, 2);

    // abort: redirect during fill
    ref_access(32'h0000_0080, m);
    pmem_lat = 3;
    bus.mem_read = 1'b1;
    bus.mem_address = 32'h0000_0080;
    @(posedge clk); #1 bus.mem_address = 32'h0000_1000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_dp_line", {5'b0, bus.dp_address[31:5]}, 32'h4);
      chk("abort_no_resp", {31'b0, bus.mem_resp}, 32'h0);
      if (bus.pmem_resp) begin
        chk("abort_fill", {31'b0, bus.load_line_data}, 32'h1);
        break;
      end
    end
    @(posedge clk); #1;
    start_req(32'h0000_1000, 2, m);
    wait_resp(cyc);
    chk("abort_new_miss_latency", cyc, 2);
    chk_counters("abort");

    // reset one cycle into FETCH, late pmem_resp
    pmem_en = 1'b0;
    bus.mem_read = 1'b1;
    bus.mem_address = 32'h0000_03E0;
    @(posedge clk); #1;
    chk("fetch_busy", {31'b0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {27'b0, bus.busy, bus.pmem_read, bus.load_line_data, bus.load_LRU, bus.mem_resp}, 32'h0);
    chk("rst_mid_counters", {24'b0, 4'(bus.hit_count), 4'(bus.miss_count)}, 32'h0);
    bus.mem_read = 1'b0;
    r_hits = 0;
    r_miss = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 pmem_force = 1'b1;
    @(negedge clk);
    chk("late_resp_ignored", {28'b0, bus.load_line_data, bus.load_valid, bus.load_LRU, bus.mem_resp}, 32'h0);
    chk("late_resp_idle", {31'b0, bus.busy}, 32'h0);
    @(posedge clk); #1 pmem_force = 1'b0;
    pmem_en = 1'b1;
    @(negedge clk);
    chk_counters("after_rst");
    @(posedge clk); #1;

    // saturation and clear
    for (int i = 0; i < 16; i++) fetch(32'h0000_0040, 1, cyc);
    chk("hit_saturate", 32'(bus.hit_count), 32'hF);
    bus.clr_counters = 1'b1;
    fetch(32'h0000_0048, 1, cyc);
    bus.clr_counters = 1'b0;
    r_hits = 0;
    r_miss = 0;
    chk_counters("clear");

    // randomized traffic over two sets with four tags each
    for (int i = 0; i < 80; i++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 1)) << 5) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 9) == 0) bus.clr_counters = 1'b1;
      fetch(a, int'($urandom_range(1, 4)), cyc);
      if (bus.clr_counters) begin
        bus.clr_counters = 1'b0;
        r_hits = 0;
        r_miss = 0;
      end
      chk_counters("rand");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
